fwnoc_router_switch_alloc: RTL and testbench
============================================

// Module: fwnoc_router_switch_alloc
// PURPOSE
// - Packet-level switch allocator for the fwnoc router crossbar. N ingress ports each present a head-of-packet request naming one egress port.
// - Each egress runs its own round-robin arbiter and stays locked to the winning ingress for the whole packet: header flit plus req_sz payload flits.
// - Drives the per-egress crossbar select lines and per-ingress grant flags. Sits beside the egress muxes, which consume sel.
// PARAMETERS
// - N_PORTS      4   number of ingress ports and of egress ports
// - SZ_W         4   width of the header payload-size field
// - TIMEOUT_CYC  64  idle cycles before a forced release; used only with FWNOC_SWALLOC_TIMEOUT_EN
// PORTS
// - clock      in   1             clock
// - reset      in   1             reset, asynchronous, active-high
// - req_valid  in   N_PORTS       ingress i has a header flit at its head
// - req_dst    in   N_PORTS*N     one-hot egress for ingress i, in bits [i*N +: N]
// - req_sz     in   N_PORTS*SZ_W  payload flit count from header for ingress i, in bits [i*SZ_W +: SZ_W]
// - xfer       in   N_PORTS       a flit of ingress i completed its egress handshake (valid&&ready) this cycle
// - sel        out  N_PORTS*N     egress j: one-hot ingress select in bits [j*N +: N]; 0 = idle
// - gnt        out  N_PORTS       ingress i currently owns an egress (OR of column i over all sel)
// - busy       out  N_PORTS       egress j locked
// - to_err     out  1             timeout pulse (FWNOC_SWALLOC_TIMEOUT_EN only; otherwise tied 0)
// BEHAVIOUR
// - Reset: sel=0, gnt=0, busy=0, to_err=0; all egress FSMs IDLE; every RR pointer = N-1, so ingress 0 has highest priority first.
// - Per-egress FSM, states IDLE and LOCK.
// - IDLE, eligible set: E_j = {i : req_valid[i] && req_dst[i][j] && !gnt[i]}.
//   - If E_j is non-empty: winner w = first member of E_j at or above ptr_j+1 (mod N); otherwise the lowest member of E_j.
//   - Registered decision: at the next edge go LOCK, set sel_j = onehot(w), ptr_j <= w, rem_j <= req_sz[w] + 1.
//   - Grant latency is 1 cycle from req_valid.
// - LOCK:
//   - Each cycle with xfer[owner]=1, decrement rem_j.
//   - If xfer[owner] && rem_j==1: next edge go IDLE and clear sel_j.
//   - xfer from non-owners is ignored by this egress.
// - Arithmetic: rem_j is SZ_W+1 bits wide. req_sz=0 means header only (rem=1). req_sz=max gives 2^SZ_W flits; no overflow.
// - Release-to-regrant: at least 1 IDLE cycle. The released egress arbitrates in the cycle after release, so back-to-back packets from different ingresses are separated by 1 cycle.
// - Ingress exclusivity:
//   - req_dst must be one-hot. A non-one-hot value is a protocol violation, flagged by a bench assertion.
//   - gnt[i]=1 removes ingress i from every E_j, so one ingress never owns two egresses.
// - Simultaneous events:
//   - Multiple egresses may grant different ingresses in the same cycle.
//   - An ingress whose req_valid drops before the grant edge is simply not granted; no state is kept.
// - req_valid or req_dst changing while gnt[i]=1 has no effect until release.
// - Reset mid-packet: lock dropped immediately (async); rem and ptr return to reset values; upstream must flush.
// - sel, gnt and busy are registered outputs. gnt and busy are derived from registered sel.
// CONFIGURATION
// - FWNOC_SWALLOC_TIMEOUT_EN defined:
//   - Per-egress idle counter, cleared on every owner xfer and on grant.
//   - When it reaches TIMEOUT_CYC in LOCK: force IDLE, clear sel_j, pulse to_err for 1 cycle.
// - FWNOC_SWALLOC_TIMEOUT_EN undefined: no counters; a lock persists until the tail xfer; to_err=0.
// TESTING
// - Single packet: ingress 2 -> egress 1, sz=3. Expect sel[1*N+:N]=4'b0100 1 cycle after req_valid. After 4 xfer[2] pulses, sel cleared; gnt[2]=0 the next cycle.
// - Contention: ingresses 0,1,3 -> egress 0, sz=0, requests held. Grant order 0,1,3,0,... Each grant lasts 1 xfer plus 1 idle cycle.
// - Parallel: ingress 0 -> egress 2 and ingress 1 -> egress 3 in the same cycle. Both granted that cycle; busy=4'b1100.
// - Ingress exclusivity: ingress 1 locked on egress 0 also asserts req_dst=egress 2. Egress 2 stays IDLE until ingress 1 releases.
// - Max size: sz=15 needs 16 xfer. Xfer stalls of 5 cycles mid-packet hold the lock; the 16th xfer releases.
// - Reset mid-packet: assert reset after 2 of 4 flits. sel, gnt and busy read 0 immediately. After reset, ingress 0 wins the first contention.
// - Timeout (EN build): TIMEOUT_CYC=8, lock with no xfer. After 8 cycles sel cleared and to_err pulses once.

Source files
------------

// File: rtl/fwnoc_router_switch_alloc.sv
// fwnoc router switch allocator: per-egress round-robin, packet-locked.
// Optional idle-timeout release when FWNOC_SWALLOC_TIMEOUT_EN is defined.
module fwnoc_router_switch_alloc #(
    parameter int N_PORTS     = 4,
    parameter int SZ_W        = 4,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [N_PORTS-1:0]           req_valid,
    input  logic [N_PORTS*N_PORTS-1:0]   req_dst,
    input  logic [N_PORTS*SZ_W-1:0]      req_sz,
    input  logic [N_PORTS-1:0]           xfer,
    output logic [N_PORTS*N_PORTS-1:0]   sel,
    output logic [N_PORTS-1:0]           gnt,
    output logic [N_PORTS-1:0]           busy,
    output logic                         to_err
);

    localparam int N  = N_PORTS;
    localparam int PW = (N > 1) ? $clog2(N) : 1;
    localparam int RW = SZ_W + 1;

    typedef enum logic {IDLE, LOCK} state_t;

    logic [N-1:0] sel_r [N];

`ifdef FWNOC_SWALLOC_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYC + 1);
    logic [N-1:0] expire;
`endif

    for (genvar j = 0; j < N; j++) begin : g_eg
        state_t       state;
        logic [PW-1:0] ptr;
        logic [RW-1:0] rem;
        logic [N-1:0]  elig;
        logic [N-1:0]  win_oh;
        logic [PW-1:0] win;
        logic [PW-1:0] idx;
        logic          any;
        logic          own_xfer;
`ifdef FWNOC_SWALLOC_TIMEOUT_EN
        logic [CW-1:0] cnt;
`endif

        always_comb begin
            elig = '0;
            for (int i = 0; i < N; i++) begin
                elig[i] = req_valid[i] && req_dst[i*N+j] && !gnt[i];
            end
        end

        // circular search starting just above the last winner
        always_comb begin
            win = ptr;
            any = 1'b0;
            idx = '0;
            for (int k = 1; k <= N; k++) begin
                idx = PW'((int'(ptr) + k) % N);
                if (!any && elig[idx]) begin
                    win = idx;
                    any = 1'b1;
                end
            end
        end

        assign win_oh   = N'(1) << win;
        assign own_xfer = |(sel_r[j] & xfer);

`ifdef FWNOC_SWALLOC_TIMEOUT_EN
        assign expire[j] = (state == LOCK) && !own_xfer &&
                           (cnt == CW'(TIMEOUT_CYC - 1));
`endif

        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                state    <= IDLE;
                ptr      <= PW'(N - 1);
                rem      <= '0;
                sel_r[j] <= '0;
`ifdef FWNOC_SWALLOC_TIMEOUT_EN
                cnt      <= '0;
`endif
            end else begin
                unique case (state)
                    IDLE: begin
                        if (any) begin
                            state    <= LOCK;
                            sel_r[j] <= win_oh;
                            ptr      <= win;
                            rem      <= {1'b0, req_sz[int'(win)*SZ_W +: SZ_W]}
                                        + RW'(1);
`ifdef FWNOC_SWALLOC_TIMEOUT_EN
                            cnt      <= '0;
`endif
                        end
                    end
                    LOCK: begin
                        if (own_xfer) begin
                            rem <= rem - RW'(1);
`ifdef FWNOC_SWALLOC_TIMEOUT_EN
                            cnt <= '0;
`endif
                            if (rem == RW'(1)) begin
                                state    <= IDLE;
                                sel_r[j] <= '0;
                            end
                        end
`ifdef FWNOC_SWALLOC_TIMEOUT_EN
                        else if (expire[j]) begin
                            state    <= IDLE;
                            sel_r[j] <= '0;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
`endif
                    end
                    default: state <= IDLE;
                endcase
            end
        end

        assign sel[j*N +: N] = sel_r[j];
    end

    always_comb begin
        gnt  = '0;
        busy = '0;
        for (int j = 0; j < N; j++) begin
            gnt     = gnt | sel_r[j];
            busy[j] = |sel_r[j];
        end
    end

`ifdef FWNOC_SWALLOC_TIMEOUT_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            to_err <= 1'b0;
        end else begin
            to_err <= |expire;
        end
    end
`else
    assign to_err = 1'b0;
`endif

endmodule

// File: tb/tb_fwnoc_router_switch_alloc.sv
// Bench for fwnoc_router_switch_alloc: vector table plus hand sequences,
// expected outputs queued on drive and compared after the edge.
module tb_fwnoc_router_switch_alloc;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  req_valid = '0;
    logic [15:0] req_dst = '0;
    logic [15:0] req_sz = '0;
    logic [3:0]  xfer = '0;
    logic [15:0] sel;
    logic [3:0]  gnt;
    logic [3:0]  busy;
    logic        to_err;

    int errors = 0;
    int checks = 0;

    fwnoc_router_switch_alloc #(
        .N_PORTS(4),
        .SZ_W(4),
        .TIMEOUT_CYC(8)
    ) dut (
        .clock(clock),
        .reset(reset),
        .req_valid(req_valid),
        .req_dst(req_dst),
        .req_sz(req_sz),
        .xfer(xfer),
        .sel(sel),
        .gnt(gnt),
        .busy(busy),
        .to_err(to_err)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (!reset) begin
            for (int i = 0; i < 4; i++) begin
                assert (!req_valid[i] || $onehot(req_dst[i*4 +: 4]))
                else $error("protocol: ingress %0d req_dst not one-hot", i);
            end
        end
    end

    typedef struct {
        logic [3:0]  v;
        logic [15:0] d;
        logic [15:0] s;
        logic [3:0]  x;
        logic [15:0] esel;
        logic [3:0]  egnt;
        logic [3:0]  ebusy;
    } vec_t;

    typedef struct {
        logic [15:0] sel;
        logic [3:0]  gnt;
        logic [3:0]  busy;
        logic        to;
        string       nm;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];

    task automatic check(input string nm, input logic [15:0] a,
                         input logic [15:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, a, e);
        end
    endtask

    // derives gnt/busy from an expected sel word (column OR, row OR)
    function automatic vec_t mk(input logic [3:0] v, input logic [15:0] d,
                                input logic [15:0] s, input logic [3:0] x,
                                input logic [15:0] es);
        vec_t t;
        t.v = v; t.d = d; t.s = s; t.x = x; t.esel = es;
        t.egnt = '0; t.ebusy = '0;
        for (int j = 0; j < 4; j++) begin
            t.egnt     = t.egnt | es[j*4 +: 4];
            t.ebusy[j] = |es[j*4 +: 4];
        end
        return t;
    endfunction

    task automatic step(input vec_t t, input logic eto, input string nm);
        exp_t e;
        @(negedge clock);
        req_valid = t.v;
        req_dst   = t.d;
        req_sz    = t.s;
        xfer      = t.x;
        e.sel = t.esel; e.gnt = t.egnt; e.busy = t.ebusy;
        e.to = eto; e.nm = nm;
        sb.push_back(e);
        @(posedge clock);
        #1;
        e = sb.pop_front();
        check({e.nm, ".sel"}, sel, e.sel);
        check({e.nm, ".gnt"}, {12'h0, gnt}, {12'h0, e.gnt});
        check({e.nm, ".busy"}, {12'h0, busy}, {12'h0, e.busy});
        check({e.nm, ".to_err"}, {15'h0, to_err}, {15'h0, e.to});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int order[5];
        order = '{0, 1, 3, 0, 1};

        tbl.push_back('{4'b0100, 16'h0200, 16'h0300, 4'b0000, 16'h0040, 4'b0100, 4'b0010});
        tbl.push_back('{4'b0000, 16'h0200, 16'h0300, 4'b0100, 16'h0040, 4'b0100, 4'b0010});
        tbl.push_back('{4'b0000, 16'h0200, 16'h0300, 4'b0100, 16'h0040, 4'b0100, 4'b0010});
        tbl.push_back('{4'b0000, 16'h0200, 16'h0300, 4'b0100, 16'h0040, 4'b0100, 4'b0010});
        tbl.push_back('{4'b0000, 16'h0200, 16'h0300, 4'b0100, 16'h0000, 4'b0000, 4'b0000});
        tbl.push_back('{4'b0011, 16'h0084, 16'h0000, 4'b0000, 16'h2100, 4'b0011, 4'b1100});
        tbl.push_back('{4'b0000, 16'h0084, 16'h0000, 4'b0011, 16'h0000, 4'b0000, 4'b0000});
        tbl.push_back('{4'b0010, 16'h0010, 16'h0010, 4'b0000, 16'h0002, 4'b0010, 4'b0001});
        tbl.push_back('{4'b0010, 16'h0040, 16'h0000, 4'b0010, 16'h0002, 4'b0010, 4'b0001});
        tbl.push_back('{4'b0010, 16'h0040, 16'h0000, 4'b0000, 16'h0002, 4'b0010, 4'b0001});
        tbl.push_back('{4'b0010, 16'h0040, 16'h0000, 4'b0010, 16'h0000, 4'b0000, 4'b0000});
        tbl.push_back('{4'b0010, 16'h0040, 16'h0000, 4'b0000, 16'h0200, 4'b0010, 4'b0100});
        tbl.push_back('{4'b0000, 16'h0040, 16'h0000, 4'b0010, 16'h0000, 4'b0000, 4'b0000});

        repeat (2) @(posedge clock);
        #1;
        check("reset.sel", sel, 16'h0);
        check("reset.gnt", {12'h0, gnt}, 16'h0);
        check("reset.busy", {12'h0, busy}, 16'h0);
        check("reset.to_err", {15'h0, to_err}, 16'h0);
        @(negedge clock);
        reset = 1'b0;

        // contention on egress 0: ingresses 0,1,3 held, sz=0
        foreach (order[k]) begin
            logic [3:0] w;
            w = 4'b0001 << order[k];
            step(mk(4'b1011, 16'h1011, 16'h0, 4'b0000, {12'h0, w}), 1'b0,
                 $sformatf("rr_gnt%0d", k));
            step(mk(4'b1011, 16'h1011, 16'h0, w, 16'h0), 1'b0,
                 $sformatf("rr_rel%0d", k));
        end

        for (int r = 0; r < tbl.size(); r++) begin
            step(tbl[r], 1'b0, $sformatf("vec%0d", r));
        end

        // max size with a 5-cycle stall
        step(mk(4'b1000, 16'h8000, 16'hF000, 4'b0000, 16'h8000), 1'b0, "max_gnt");
        for (int k = 1; k <= 16; k++) begin
            step(mk(4'b0000, 16'h8000, 16'hF000, 4'b1000,
                    (k == 16) ? 16'h0 : 16'h8000), 1'b0,
                 $sformatf("max_x%0d", k));
            if (k == 8) begin
                for (int st = 0; st < 5; st++) begin
                    step(mk(4'b0000, 16'h8000, 16'hF000, 4'b0000, 16'h8000),
                         1'b0, $sformatf("max_stall%0d", st));
                end
            end
        end

        // reset mid-packet
        step(mk(4'b0001, 16'h0002, 16'h0003, 4'b0000, 16'h0010), 1'b0, "rst_gnt");
        step(mk(4'b0000, 16'h0002, 16'h0003, 4'b0001, 16'h0010), 1'b0, "rst_x1");
        step(mk(4'b0000, 16'h0002, 16'h0003, 4'b0001, 16'h0010), 1'b0, "rst_x2");
        @(negedge clock);
        xfer  = '0;
        reset = 1'b1;
        #1;
        check("rst_mid.sel", sel, 16'h0);
        check("rst_mid.gnt", {12'h0, gnt}, 16'h0);
        check("rst_mid.busy", {12'h0, busy}, 16'h0);
        @(negedge clock);
        reset = 1'b0;
        step(mk(4'b0101, 16'h0202, 16'h0, 4'b0000, 16'h0010), 1'b0, "post_rst_gnt");
        step(mk(4'b0000, 16'h0202, 16'h0, 4'b0001, 16'h0000), 1'b0, "post_rst_rel");

`ifdef FWNOC_SWALLOC_TIMEOUT_EN
        step(mk(4'b0001, 16'h0001, 16'h0, 4'b0000, 16'h0001), 1'b0, "to_gnt");
        for (int k = 1; k <= 8; k++) begin
            step(mk(4'b0000, 16'h0001, 16'h0, 4'b0000,
                    (k < 8) ? 16'h0001 : 16'h0), (k == 8),
                 $sformatf("to_c%0d", k));
        end
        step(mk(4'b0000, 16'h0001, 16'h0, 4'b0000, 16'h0), 1'b0, "to_after");
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
